// File: rtl/mips_multicycle_if.sv
// Core-side bundle: instruction-memory port, step control, status/retire outputs, debug register read.
// master = the core, slave = the environment that supplies instructions and watches status.
interface mips_multicycle_if #(
  parameter int DATA_W  = 32,
  parameter int COUNT_W = 16
);
  logic               step_mode;
  logic               step;
  logic [31:0]        imem_addr;
  logic [31:0]        imem_data;
  logic [31:0]        pc_out;
  logic               retired;
  logic [COUNT_W-1:0] retired_count;
  logic               halted;
  logic [4:0]         dbg_raddr;
  logic [DATA_W-1:0]  dbg_rdata;

  modport master (
    input  step_mode, step, imem_data, dbg_raddr,
    output imem_addr, pc_out, retired, retired_count, halted, dbg_rdata
  );

  modport slave (
    output step_mode, step, imem_data, dbg_raddr,
    input  imem_addr, pc_out, retired, retired_count, halted, dbg_rdata
  );
endinterface

// File: rtl/mips_multicycle.sv
// Multi-cycle MIPS subset: FETCH/DECODE/EXEC/MEM/WB sequencing one ALU; CPI 3 (branch/jump/halt/unknown), 4 (R/addi/sw), 5 (lw).
// Single-step releases one whole instruction per step rising edge seen in FETCH; HALT parks the core until reset.
module mips_multicycle #(
  parameter int DATA_W     = 32,
  parameter int DMEM_DEPTH = 256,
  parameter int COUNT_W    = 16
) (
  input  logic clock,
  input  logic reset,
  mips_multicycle_if.master bus
);
  localparam int AW = $clog2(DMEM_DEPTH);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  state_t             state;
  logic [31:0]        pc;
  logic [31:0]        ir;
  logic [DATA_W-1:0]  rf [32];
  logic [DATA_W-1:0]  dmem [DMEM_DEPTH];
  logic [DATA_W-1:0]  a, b, imm, alu, mdr;
  logic               step_q;
  logic               retired_q;
  logic               halted_q;
  logic [COUNT_W-1:0] count;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic        is_r, is_addi, is_lw, is_sw, is_beq, is_bne, is_j, is_halt, multi;
  logic        taken, step_edge;
  logic [31:0] pc_plus4, imm32, exec_pc;
  logic [DATA_W-1:0] imm_ext, alu_r, ea, wdata;
  logic [4:0]  wdest;
  logic [AW-1:0] didx;

  assign op      = ir[31:26];
  assign funct   = ir[5:0];
  assign rs      = ir[25:21];
  assign rt      = ir[20:16];
  assign rd      = ir[15:11];
  assign is_r    = (op == 6'h00) && (funct == 6'h20 || funct == 6'h22 || funct == 6'h24 ||
                                     funct == 6'h25 || funct == 6'h2A);
  assign is_addi = (op == 6'h08);
  assign is_lw   = (op == 6'h23);
  assign is_sw   = (op == 6'h2B);
  assign is_beq  = (op == 6'h04);
  assign is_bne  = (op == 6'h05);
  assign is_j    = (op == 6'h02);
  assign is_halt = (op == 6'h3F);
  assign multi   = is_r | is_addi | is_lw | is_sw;

  assign imm_ext  = DATA_W'($signed(ir[15:0]));
  assign imm32    = {{16{ir[15]}}, ir[15:0]};
  assign pc_plus4 = pc + 32'd4;
  assign taken    = (is_beq && (a == b)) || (is_bne && (a != b));
  // Branch/jump targets are always formed in 32 bits from the IR, independent of DATA_W.
  assign exec_pc  = taken ? (pc_plus4 + (imm32 << 2)) :
                    is_j  ? {pc_plus4[31:28], ir[25:0], 2'b00} : pc_plus4;
  assign ea       = a + imm;
  assign didx     = alu[AW+1:2];
  assign wdest    = is_r ? rd : rt;
  assign wdata    = is_lw ? mdr : alu;
  assign step_edge = bus.step & ~step_q;

  always_comb begin
    alu_r = '0;
    case (funct)
      6'h20:   alu_r = a + b;
      6'h22:   alu_r = a - b;
      6'h24:   alu_r = a & b;
      6'h25:   alu_r = a | b;
      6'h2A:   alu_r = ($signed(a) < $signed(b)) ? DATA_W'(1) : '0;
      default: alu_r = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= S_FETCH;
      pc        <= '0;
      ir        <= '0;
      a         <= '0;
      b         <= '0;
      imm       <= '0;
      alu       <= '0;
      mdr       <= '0;
      step_q    <= 1'b0;
      retired_q <= 1'b0;
      halted_q  <= 1'b0;
      count     <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      step_q    <= bus.step;
      retired_q <= 1'b0;
      // retired_q is set on entry to an instruction's final state so it is high during that state.
      case (state)
        S_FETCH: begin
          if (!bus.step_mode || step_edge) begin
            ir    <= bus.imem_data;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          a         <= rf[rs];
          b         <= rf[rt];
          imm       <= imm_ext;
          retired_q <= ~multi;
          state     <= S_EXEC;
        end
        S_EXEC: begin
          if (multi) begin
            alu       <= is_r ? alu_r : ea;
            retired_q <= is_r | is_addi | is_sw;
            state     <= (is_r || is_addi) ? S_WB : S_MEM;
          end else begin
            count <= count + COUNT_W'(1);
            if (is_halt) begin
              halted_q <= 1'b1;
              state    <= S_HALT;
            end else begin
              pc    <= exec_pc;
              state <= S_FETCH;
            end
          end
        end
        S_MEM: begin
          if (is_sw) begin
            pc    <= pc_plus4;
            count <= count + COUNT_W'(1);
            state <= S_FETCH;
          end else begin
            mdr       <= dmem[didx];
            retired_q <= 1'b1;
            state     <= S_WB;
          end
        end
        S_WB: begin
          if (wdest != 5'd0) rf[wdest] <= wdata;
          pc    <= pc_plus4;
          count <= count + COUNT_W'(1);
          state <= S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  // Data memory is deliberately left out of reset; a reset cycle still blocks the store.
  always_ff @(posedge clock) begin
    if (reset && state == S_MEM && is_sw) dmem[didx] <= b;
  end

  assign bus.imem_addr     = pc;
  assign bus.pc_out        = pc;
  assign bus.retired       = retired_q;
  assign bus.retired_count = count;
  assign bus.halted        = halted_q;
  assign bus.dbg_rdata     = (bus.dbg_raddr == 5'd0) ? '0 : rf[bus.dbg_raddr];

  logic unused_ok;
  assign unused_ok = ^{ir[10:6], alu[DATA_W-1:AW+2], alu[1:0]};
endmodule

// File: doc/mips_multicycle.md
Name: mips_multicycle

Overview:
- Parametrised multi-cycle successor to the single-cycle MIPS core: one shared ALU is sequenced by an FSM (FETCH/DECODE/EXEC/MEM/WB), so CPI depends on instruction class.
- Adds configurable data width and data-memory depth, a retired-instruction counter, a HALT instruction, and a clean run/single-step mode.
- Single-step advances exactly one whole instruction per step pulse.
- Instruction memory is external and combinational; data memory and register file are internal.

Parameters:
DATA_W, 32, datapath/register/data-memory word width (>=16)
DMEM_DEPTH, 256, data memory words (power of 2)
COUNT_W, 16, width of retired-instruction counter

Ports:
clock  in  1  system clock, all state on posedge
reset  in  1  synchronous, active-low reset
step_mode  in  1  1: single-step, 0: free-run
step  in  1  step request; rising edge (registered internally) releases one instruction
imem_addr  out  32  byte address of instruction (= pc)
imem_data  in  32  instruction word, combinational from imem_addr
pc_out  out  32  current pc
retired  out  1  one-cycle pulse in the final cycle of each instruction
retired_count  out  COUNT_W  instructions completed, wraps
halted  out  1  HALT executed
dbg_raddr  in  5  debug register select
dbg_rdata  out  DATA_W  combinational register read ($0 reads 0)

Behaviour:
- Reset (reset==0 at posedge): pc=0, all registers=0, state=FETCH, retired=0, retired_count=0, halted=0, step edge detector cleared. Data memory is not cleared. Reset overrides everything, including mid-instruction; no partial writes commit in that cycle.
- FETCH: latch imem_data into IR. In step mode, stay in FETCH without latching until a step rising edge is seen. A held-high step gives one instruction only. An edge that arrives while not in FETCH is ignored.
- DECODE: read rs/rt into A/B; sign-extend imm[15:0] to DATA_W.
- EXEC actions:
  - R-type: ALU(A,B) per funct: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed).
  - addi 0x08: A+imm.
  - lw 0x23 / sw 0x2B: address A+imm.
  - beq 0x04 / bne 0x05: compare A,B; if taken, pc=pc+4+(imm<<2), else pc+4; retire.
  - j 0x02: pc={pc+4[31:28],target,2'b00}; retire.
  - HALT 0x3F: set halted; retire; FSM then stays in HALT until reset.
  - Any other opcode or funct: no register/memory write; pc+4; retire.
- MEM: sw writes B to dmem[addr[log2(DMEM_DEPTH)+1:2]] (low 2 bits ignored, upper bits wrap), pc+4, retire. lw reads into MDR.
- WB: R-type writes rd; addi writes rt; lw writes rt from MDR. pc+4; retire. Writes to $0 are discarded.
- Latency (cycles incl. FETCH): branch/jump/unknown/HALT 3; R/addi/sw 4; lw 5. In step mode, wait cycles in FETCH are extra.
- pc updates only on the retire cycle, so pc_out is stable during an instruction. pc is 32-bit and wraps.
- Arithmetic is modulo 2^DATA_W. No overflow traps.
- When branch/jump target computation exceeds DATA_W: pc arithmetic is always 32-bit, independent of DATA_W.
- retired pulses in the cycle the instruction's last state is active. retired_count increments on that same edge and wraps from 2^COUNT_W-1 to 0.
- step_mode may change at any time; it takes effect at the next FETCH.
- HALT state: no imem sampling effect, no writes, retired=0, halted=1.

Test Plan:
- Reset/run: program addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; HALT, free-run. Required: $3=2 via dbg port, retired_count=4, halted=1 after exactly 4+4+4+3=15 cycles from reset release, pc_out=0x0C.
- Memory: addi $1,$0,0x1234; sw $1,8($0); lw $4,8($0); HALT. Required: $4=0x1234. The lw retire pulse occurs 5 cycles after its FETCH. Also sw at address 8+4*DMEM_DEPTH aliases to word 2.
- Branch/jump: beq $0,$0,+2 skips two instructions (pc 0→0x0C); bne $0,$0,+2 not taken (pc+4); j 0x10 sets pc=0x40. Each takes 3 cycles.
- Single-step: step_mode=1, hold step high 20 cycles → exactly one instruction retires. Three separate pulses → retired_count=3 and no further progress without step.
- $0 and slt: add $0,$1,$1 leaves $0=0. slt with $1=-1, $2=1 writes 1; operands swapped writes 0.
- Reset mid-lw (in MEM state) → regs 0, pc 0, retired_count 0 next cycle; the lw target register is not written. With COUNT_W=2, 5 retires give count=1.
